// File: rtl/prefetch_queue.sv
// prefetch_queue: credit-limited instruction prefetcher with a serial address
// link (tx) and a serial response link (rx) feeding a small FIFO.
// Optional feature macro: PREFETCH_FLUSH_STATS_EN adds a saturating
// flush_count output that counts responses discarded after a jump.
module prefetch_queue #(
  parameter int IO_BITS        = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int DEPTH          = 2,
  parameter int ADDR_STEP      = 2,
  parameter int RESET_PC       = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  output logic [IO_BITS*PAYLOAD_CYCLES-1:0] inst,
  output logic                              inst_valid,
  input  logic                              inst_ready,
  input  logic                              jump,
  input  logic [IO_BITS*PAYLOAD_CYCLES-1:0] jump_pc,
  output logic                              tx_command_valid,
  input  logic                              tx_command_started,
  output logic [IO_BITS-1:0]                tx_data,
  input  logic                              tx_data_next,
  input  logic                              rx_data_valid,
  input  logic [IO_BITS-1:0]                rx_pins,
  input  logic                              rx_done
`ifdef PREFETCH_FLUSH_STATS_EN
  ,
  output logic [15:0]                       flush_count
`endif
);
  localparam int INST_BITS = IO_BITS * PAYLOAD_CYCLES;
  localparam int PC_BITS   = INST_BITS;
  localparam int CW        = $clog2(DEPTH + 1);
  localparam int PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW        = (PAYLOAD_CYCLES > 1) ? $clog2(PAYLOAD_CYCLES) : 1;

  logic [CW-1:0]        count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PC_BITS-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic [TW-1:0]        tx_cnt_q, tx_cnt_d;
  logic                 tx_busy_q, tx_busy_d;
  logic [INST_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [INST_BITS-1:0] mem_q [DEPTH];
  logic [INST_BITS-1:0] rx_word;
  logic [CW:0]          credit_sum;
  logic                 push, pop, drop;

  // Circular pointer advance that also handles non-power-of-two depths.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // The final slice is taken straight from the pins so a word can be pushed
  // in the same cycle its last slice arrives.
  assign rx_word    = {rx_pins, rx_shift_q[INST_BITS-1:IO_BITS]};
  assign push       = rx_done && (discard_q == '0);
  assign drop       = rx_done && (discard_q != '0);
  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst       = mem_q[rd_ptr_q];
  assign tx_data    = tx_shift_q[IO_BITS-1:0];

  // Requests are offered only while a queue slot is guaranteed for the answer.
  always_comb begin
    credit_sum       = {1'b0, inflight_q} + {1'b0, count_q};
    tx_command_valid = reset_n && (credit_sum < (CW+1)'(DEPTH)) && !tx_busy_q && !jump;
  end

  // FIFO occupancy and pointers; a jump flushes after any same-cycle pop.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (jump) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  // Outstanding-request and discard bookkeeping; responses to requests issued
  // before a jump are counted off here and dropped.
  always_comb begin
    case ({tx_command_started, rx_done})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    discard_d = discard_q;
    if (drop) discard_d = discard_q - CW'(1);
    if (jump) discard_d = inflight_d;
  end

  // Fetch address and the address serializer.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_busy_d  = tx_busy_q;
    if (tx_command_started) begin
      fetch_pc_d = fetch_pc_q + PC_BITS'(ADDR_STEP);
      tx_shift_d = fetch_pc_q;
      tx_cnt_d   = '0;
      tx_busy_d  = 1'b1;
    end else if (tx_data_next && tx_busy_q) begin
      tx_shift_d = tx_shift_q >> IO_BITS;
      tx_cnt_d   = tx_cnt_q + TW'(1);
      if (tx_cnt_q == TW'(PAYLOAD_CYCLES - 1)) tx_busy_d = 1'b0;
    end
    if (jump) fetch_pc_d = jump_pc;
  end

  // Response deserializer: slices enter at the MSB end, LSB slice first.
  always_comb begin
    rx_shift_d = rx_shift_q;
    if (rx_data_valid) rx_shift_d = rx_word;
  end

  // Control state, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= PC_BITS'(RESET_PC);
      tx_cnt_q   <= '0;
      tx_busy_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_busy_q  <= tx_busy_d;
    end
  end

  // Datapath storage is left unreset; valids qualify it.
  always_ff @(posedge clk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
    if (push) mem_q[wr_ptr_q] <= rx_word;
  end

`ifdef PREFETCH_FLUSH_STATS_EN
  logic [15:0] flush_count_q, flush_count_d;

  // Saturating count of discarded responses.
  always_comb begin
    flush_count_d = flush_count_q;
    if (drop && (flush_count_q != 16'hFFFF)) flush_count_d = flush_count_q + 16'd1;
  end

  // Statistics register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) flush_count_q <= '0;
    else          flush_count_q <= flush_count_d;
  end

  assign flush_count = flush_count_q;
`else
  // Statistics counter not built; discards are still tracked by discard_q.
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue (default parameters, 16-bit words).
module tb_prefetch_queue;
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] jump_pc = '0;
  logic        tx_command_valid;
  logic        tx_command_started = 1'b0;
  logic [1:0]  tx_data;
  logic        tx_data_next = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic [1:0]  rx_pins = '0;
  logic        rx_done = 1'b0;
`ifdef PREFETCH_FLUSH_STATS_EN
  logic [15:0] flush_count;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  prefetch_queue dut (
    .clk(clk), .reset_n(reset_n),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .jump(jump), .jump_pc(jump_pc),
    .tx_command_valid(tx_command_valid), .tx_command_started(tx_command_started),
    .tx_data(tx_data), .tx_data_next(tx_data_next),
    .rx_data_valid(rx_data_valid), .rx_pins(rx_pins), .rx_done(rx_done)
`ifdef PREFETCH_FLUSH_STATS_EN
    , .flush_count(flush_count)
`endif
  );

  typedef struct {
    logic [15:0] exp_addr;
    logic [15:0] rx_word;
    logic [15:0] exp_inst;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a command slot, accept it and collect the 8 slices.
  task automatic do_request(output logic [15:0] a, output logic ok);
    int n = 0;
    a = '0;
    while (!tx_command_valid && n < 50) begin
      step();
      n++;
    end
    ok = tx_command_valid;
    if (!ok) return;
    tx_command_started = 1'b1;
    step();
    tx_command_started = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a[i*2 +: 2] = tx_data;
      tx_data_next = 1'b1;
      step();
      tx_data_next = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 0; i < 8; i++) begin
      rx_pins       = w[i*2 +: 2];
      rx_data_valid = 1'b1;
      rx_done       = (i == 7);
      step();
    end
    rx_data_valid = 1'b0;
    rx_done       = 1'b0;
  endtask

  task automatic req_check(input string name, input logic [15:0] exp_addr);
    logic [15:0] a;
    logic        ok;
    do_request(a, ok);
    check({name, "_cmd_wait"}, {31'd0, ok}, 32'd1);
    if (ok) check({name, "_addr"}, {16'd0, a}, {16'd0, exp_addr});
  endtask

  initial begin
    logic [15:0] a;
    vecs[0] = '{16'h0004, 16'hA5A5, 16'hA5A5};
    vecs[1] = '{16'h0006, 16'h0001, 16'h0001};
    vecs[2] = '{16'h0008, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{16'h000A, 16'h8000, 16'h8000};

    // reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_cmd_valid", {31'd0, tx_command_valid}, 32'd0);
    step(); step();
    reset_n = 1'b1;
    #1;
    check("post_rst_cmd_valid", {31'd0, tx_command_valid}, 32'd1);
`ifdef PREFETCH_FLUSH_STATS_EN
    check("rst_flush_count", {16'd0, flush_count}, 32'd0);
`endif

    // first two requests, then credits exhausted
    req_check("req0", 16'h0000);
    req_check("req1", 16'h0002);
    check("credits_full", {31'd0, tx_command_valid}, 32'd0);

    // response latency and hold with inst_ready low
    send_word(16'hBEEF);
    check("beef_valid", {31'd0, inst_valid}, 32'd1);
    check("beef_inst", {16'd0, inst}, 32'h0000BEEF);
    check("cmd_blocked_sum2", {31'd0, tx_command_valid}, 32'd0);
    send_word(16'h1234);
    check("hold_head", {16'd0, inst}, 32'h0000BEEF);

    // drain two entries back to back
    inst_ready = 1'b1;
    check("pop0", {16'd0, inst}, 32'h0000BEEF);
    step();
    check("pop1_valid", {31'd0, inst_valid}, 32'd1);
    check("pop1", {16'd0, inst}, 32'h00001234);
    step();
    check("drained", {31'd0, inst_valid}, 32'd0);
    inst_ready = 1'b0;

    // table-driven request/response round trips
    for (int k = 0; k < 4; k++) begin
      req_check($sformatf("vec%0d", k), vecs[k].exp_addr);
      send_word(vecs[k].rx_word);
      check($sformatf("vec%0d_valid", k), {31'd0, inst_valid}, 32'd1);
      check($sformatf("vec%0d_inst", k), {16'd0, inst}, {16'd0, vecs[k].exp_inst});
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      check($sformatf("vec%0d_popped", k), {31'd0, inst_valid}, 32'd0);
    end

    // jump with two requests in flight: both answers dropped
    req_check("jreq0", 16'h000C);
    req_check("jreq1", 16'h000E);
    jump = 1'b1;
    jump_pc = 16'h0100;
    #1;
    check("jump_blocks_cmd", {31'd0, tx_command_valid}, 32'd0);
    step();
    jump = 1'b0;
    send_word(16'hDEAD);
    check("drop0", {31'd0, inst_valid}, 32'd0);
    send_word(16'hCAFE);
    check("drop1", {31'd0, inst_valid}, 32'd0);
`ifdef PREFETCH_FLUSH_STATS_EN
    check("flush_count_2", {16'd0, flush_count}, 32'd2);
`endif
    req_check("after_jump", 16'h0100);
    send_word(16'h7777);
    check("after_jump_inst", {16'd0, inst}, 32'h00007777);

    // jump coinciding with a pop empties the queue
    inst_ready = 1'b1;
    jump = 1'b1;
    jump_pc = 16'h0200;
    step();
    jump = 1'b0;
    inst_ready = 1'b0;
    check("flush_pop_valid", {31'd0, inst_valid}, 32'd0);
    req_check("after_jump2", 16'h0200);
    send_word(16'h4242);
    check("after_jump2_valid", {31'd0, inst_valid}, 32'd1);
    check("after_jump2_inst", {16'd0, inst}, 32'h00004242);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    check("after_jump2_popped", {31'd0, inst_valid}, 32'd0);

    // jump after 3 of 8 address slices: old address finishes, answer dropped
    a = '0;
    check("mid_cmd_ready", {31'd0, tx_command_valid}, 32'd1);
    tx_command_started = 1'b1;
    step();
    tx_command_started = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        jump = 1'b1;
        jump_pc = 16'h0100;
        #1;
        check("busy_blocks_cmd", {31'd0, tx_command_valid}, 32'd0);
        step();
        jump = 1'b0;
      end
      a[i*2 +: 2] = tx_data;
      tx_data_next = 1'b1;
      step();
      tx_data_next = 1'b0;
    end
    check("mid_jump_old_addr", {16'd0, a}, 32'h00000202);
    send_word(16'h5555);
    check("mid_jump_drop", {31'd0, inst_valid}, 32'd0);
`ifdef PREFETCH_FLUSH_STATS_EN
    check("flush_count_3", {16'd0, flush_count}, 32'd3);
`endif
    req_check("mid_jump_next", 16'h0100);
    send_word(16'h6666);
    check("mid_jump_next_inst", {16'd0, inst}, 32'h00006666);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;

    // reset in the middle of a receive
    req_check("pre_rst_req0", 16'h0102);
    send_word(16'h1111);
    check("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
    req_check("pre_rst_req1", 16'h0104);
    for (int i = 0; i < 4; i++) begin
      rx_pins = 2'b11;
      rx_data_valid = 1'b1;
      step();
    end
    rx_data_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrx_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("midrx_rst_cmd_valid", {31'd0, tx_command_valid}, 32'd0);
    step();
    reset_n = 1'b1;
    #1;
`ifdef PREFETCH_FLUSH_STATS_EN
    check("midrx_rst_flush", {16'd0, flush_count}, 32'd0);
`endif
    req_check("restart", 16'h0000);
    send_word(16'h0F0F);
    check("restart_valid", {31'd0, inst_valid}, 32'd1);
    check("restart_inst", {16'd0, inst}, 32'h00000F0F);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
